rvfi_trace_buffer: RTL and testbench

Retirement-trace capture stage sitting directly downstream of the `riscv.Hart` RVFI port. It samples every retired-instruction packet, checks `rvfi_order` continuity, and buffers records in a FIFO of DEPTH entries. It serializes each record as four 32-bit words onto a valid/ready debug stream for a UART/JTAG trace sink. Overflow is counted and flagged rather than back-pressuring the hart, which has no stall input for trace.

---
 rtl/rvfi_trace_buffer.sv | 111 +++++++++++
 tb/tb_rvfi_trace_buffer.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rvfi_trace_buffer.sv
// rvfi_trace_buffer: captures RVFI retirements into a record FIFO and streams
// each record as four 32-bit words; overflow drops records instead of stalling.
module rvfi_trace_buffer #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rvfi_valid,
  input  logic [63:0] rvfi_order,
  input  logic [31:0] rvfi_insn,
  input  logic        rvfi_trap,
  input  logic        rvfi_halt,
  input  logic [31:0] rvfi_pc_rdata,
  input  logic [4:0]  rvfi_rd_addr,
  input  logic [31:0] rvfi_rd_wdata,
  input  logic [3:0]  rvfi_mem_wmask,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic [15:0] drop_count,
  output logic        halted
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {IDLE, SEND} state_t;
  state_t      r_state, w_state_n;
  logic [1:0]  r_idx, w_idx_n;
  logic [AW:0] r_wr, r_rd, w_wr_n, w_rd_n;
  logic [31:0] r_mem [DEPTH][4];
  logic [63:0] r_last;
  logic        r_have_prev, r_povf, r_stop, r_halted;
  logic [15:0] r_drop;
  logic        w_full, w_empty, w_hs, w_pop, w_act, w_push, w_drop, w_gap;
  logic [31:0] w_flags;

  assign w_full    = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_empty   = r_wr == r_rd;
  assign out_valid = r_state == SEND;
  assign w_hs      = out_valid && out_ready;
  assign w_pop     = w_hs && r_idx == 2'd3;
  assign w_act     = rvfi_valid && !r_stop;
  assign w_push    = w_act && (!w_full || w_pop);
  assign w_drop    = w_act && w_full && !w_pop;
  assign w_gap     = r_have_prev && rvfi_order != r_last + 64'd1;
  assign w_flags   = {rvfi_order[15:0], rvfi_rd_addr, rvfi_mem_wmask, rvfi_trap,
                      rvfi_halt, w_gap, r_povf, 3'b000};
  assign w_wr_n    = r_wr + (AW+1)'(w_push);
  assign w_rd_n    = r_rd + (AW+1)'(w_pop);
  // head word is read straight from the FIFO, so it holds while stalled
  assign out_data   = out_valid ? r_mem[r_rd[AW-1:0]][r_idx] : '0;
  assign out_last   = out_valid && r_idx == 2'd3;
  assign drop_count = r_drop;
  assign halted     = r_halted;

  always_comb begin
    w_state_n = r_state;
    w_idx_n   = r_idx;
    if (r_state == IDLE) begin
      w_state_n = w_empty ? IDLE : SEND;
      w_idx_n   = 2'd0;
    end else if (w_hs) begin
      w_idx_n   = r_idx + 2'd1;
      w_state_n = (w_pop && w_wr_n == w_rd_n) ? IDLE : SEND;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= 2'd0;
    end else begin
      r_state <= w_state_n;
      r_idx   <= w_idx_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr        <= '0;
      r_rd        <= '0;
      r_last      <= '0;
      r_have_prev <= 1'b0;
      r_povf      <= 1'b0;
      r_stop      <= 1'b0;
      r_halted    <= 1'b0;
      r_drop      <= '0;
    end else begin
      r_wr <= w_wr_n;
      r_rd <= w_rd_n;
      // drops still advance the order tracker so they never look like a gap
      if (w_act) begin
        r_last      <= rvfi_order;
        r_have_prev <= 1'b1;
        if (rvfi_halt) r_stop <= 1'b1;
      end
      if (w_push) r_povf <= 1'b0;
      else if (w_drop) r_povf <= 1'b1;
      if (w_drop && r_drop != 16'hFFFF) r_drop <= r_drop + 16'd1;
      if (w_pop && r_mem[r_rd[AW-1:0]][3][5]) r_halted <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr[AW-1:0]][0] <= rvfi_pc_rdata;
      r_mem[r_wr[AW-1:0]][1] <= rvfi_insn;
      r_mem[r_wr[AW-1:0]][2] <= rvfi_rd_wdata;
      r_mem[r_wr[AW-1:0]][3] <= w_flags;
    end
  end
endmodule

// File: tb/tb_rvfi_trace_buffer.sv
// tb_rvfi_trace_buffer: directed and random checks of rvfi_trace_buffer against a queue-based record model
module tb_rvfi_trace_buffer;
  localparam int DEPTH = 8;
  logic        clk = 1'b0, rst = 1'b1;
  logic        rvfi_valid = 1'b0, rvfi_trap = 1'b0, rvfi_halt = 1'b0, out_ready = 1'b0;
  logic [63:0] rvfi_order = '0;
  logic [31:0] rvfi_insn = '0, rvfi_pc_rdata = '0, rvfi_rd_wdata = '0;
  logic [4:0]  rvfi_rd_addr = '0;
  logic [3:0]  rvfi_mem_wmask = '0;
  logic        out_valid, out_last, halted;
  logic [31:0] out_data;
  logic [15:0] drop_count;

  rvfi_trace_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order),
    .rvfi_insn(rvfi_insn), .rvfi_trap(rvfi_trap), .rvfi_halt(rvfi_halt),
    .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rd_wdata(rvfi_rd_wdata),
    .rvfi_mem_wmask(rvfi_mem_wmask), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .drop_count(drop_count), .halted(halted));

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  logic [127:0] mq[$];
  int          m_pos, m_drop;
  bit          m_busy, m_have, m_povf, m_stop, m_halted;
  logic [63:0] m_last;
  logic [31:0] got_w[$];
  logic        got_l[$];

  function automatic logic [50:0] dut_vec();
    return {out_valid, out_last, out_data, drop_count, halted};
  endfunction

  function automatic logic [50:0] exp_vec();
    logic [31:0] ed;
    ed = (m_busy && mq.size() > 0) ? mq[0][m_pos*32 +: 32] : 32'h0;
    return {m_busy, m_busy && m_pos == 3, ed, m_drop[15:0], m_halted};
  endfunction

  task automatic model_update();
    bit was_ne, hs, pop, act, full, push, drop, gap;
    was_ne = mq.size() != 0;
    if (rst) begin
      mq.delete(); m_pos = 0; m_busy = 0; m_last = '0; m_have = 0;
      m_povf = 0; m_stop = 0; m_halted = 0; m_drop = 0;
      return;
    end
    hs   = m_busy && out_ready;
    pop  = hs && m_pos == 3;
    act  = rvfi_valid && !m_stop;
    full = mq.size() == DEPTH;
    push = act && (!full || pop);
    drop = act && full && !pop;
    gap  = m_have && (rvfi_order != m_last + 64'd1);
    if (act) begin
      m_last = rvfi_order; m_have = 1;
      if (rvfi_halt) m_stop = 1;
    end
    if (pop) begin
      if (mq[0][96+5]) m_halted = 1;
      void'(mq.pop_front());
      m_pos = 0;
    end else if (hs) m_pos++;
    if (push) begin
      mq.push_back({rvfi_order[15:0], rvfi_rd_addr, rvfi_mem_wmask, rvfi_trap, rvfi_halt,
                    gap, m_povf, 3'b000, rvfi_rd_wdata, rvfi_insn, rvfi_pc_rdata});
      m_povf = 0;
    end
    if (drop) begin
      if (m_drop < 65535) m_drop++;
      m_povf = 1;
    end
    if (m_busy) m_busy = !(pop && mq.size() == 0);
    else begin
      m_busy = was_ne; m_pos = 0;
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (out_valid && out_ready) begin
      got_w.push_back(out_data); got_l.push_back(out_last);
    end
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set_rec(input logic [63:0] o, input logic [31:0] pc, input logic [31:0] insn,
                         input logic [31:0] wd, input logic [4:0] rd, input logic hl);
    rvfi_valid = 1; rvfi_order = o; rvfi_pc_rdata = pc; rvfi_insn = insn;
    rvfi_rd_wdata = wd; rvfi_rd_addr = rd; rvfi_halt = hl;
    rvfi_trap = 0; rvfi_mem_wmask = '0;
  endtask

  task automatic do_reset();
    rvfi_valid = 0; rvfi_halt = 0; rst = 1;
    step();
    rst = 0;
    got_w.delete(); got_l.delete();
  endtask

  task automatic test_reset();
    rst = 1; rvfi_valid = 0; out_ready = 0;
    step(); step();
    rst = 0;
    n_cmp++;
    if (dut_vec() !== 51'b0) begin
      n_bad++; $display("FAIL reset: got %h exp 0", dut_vec());
    end
    n_cmp++;
    if (dut_vec() !== exp_vec()) begin
      n_bad++; $display("FAIL reset_model: got %h exp %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_single();
    logic [31:0] ew[4];
    ew = '{32'h00000100, 32'h00500093, 32'h00000005, 32'h00050800};
    do_reset();
    out_ready = 1;
    set_rec(64'd5, 32'h100, 32'h00500093, 32'd5, 5'd1, 1'b0);
    step();
    rvfi_valid = 0;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL single_lat0: out_valid got %b exp 0", out_valid);
    end
    step();
    n_cmp++;
    if ({out_valid, out_data} !== {1'b1, 32'h100}) begin
      n_bad++; $display("FAIL single_lat1: got v%b %h exp v1 00000100", out_valid, out_data);
    end
    repeat (5) begin
      step(); n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL single_cyc: got %h exp %h", dut_vec(), exp_vec());
      end
    end
    n_cmp++;
    if (got_w.size() != 4) begin
      n_bad++; $display("FAIL single_count: got %0d exp 4", got_w.size());
    end
    for (int i = 0; i < 4 && i < got_w.size(); i++) begin
      n_cmp++;
      if ({got_w[i], got_l[i]} !== {ew[i], i == 3}) begin
        n_bad++; $display("FAIL single_w%0d: got %h last %b exp %h last %b", i, got_w[i], got_l[i], ew[i], i == 3);
      end
    end
  endtask

  task automatic test_gap();
    logic [63:0] ords[3];
    ords = '{64'd0, 64'd1, 64'd3};
    do_reset();
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      set_rec(ords[i], $urandom, $urandom, $urandom, 5'($urandom), 1'b0);
      step(); n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL gap_push: got %h exp %h", dut_vec(), exp_vec());
      end
    end
    rvfi_valid = 0;
    repeat (16) begin
      step(); n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL gap_cyc: got %h exp %h", dut_vec(), exp_vec());
      end
    end
    n_cmp++;
    if (got_w.size() != 12) begin
      n_bad++; $display("FAIL gap_count: got %0d exp 12", got_w.size());
    end else
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (got_w[4*i+3][4] !== (i == 2)) begin
          n_bad++; $display("FAIL gap_bit rec%0d: got %b exp %b", i, got_w[4*i+3][4], i == 2);
        end
      end
  endtask

  task automatic test_overflow();
    do_reset();
    out_ready = 0;
    for (int i = 0; i < 10; i++) begin
      set_rec(64'(i), $urandom, $urandom, $urandom, 5'($urandom), 1'b0);
      step(); n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL ovf_fill: got %h exp %h", dut_vec(), exp_vec());
      end
    end
    rvfi_valid = 0;
    n_cmp++;
    if (drop_count !== 16'd2) begin
      n_bad++; $display("FAIL ovf_drops: got %0d exp 2", drop_count);
    end
    out_ready = 1;
    repeat (34) begin
      step(); n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL ovf_drain: got %h exp %h", dut_vec(), exp_vec());
      end
    end
    n_cmp++;
    if (got_w.size() != 32) begin
      n_bad++; $display("FAIL ovf_count: got %0d exp 32", got_w.size());
    end else
      for (int k = 0; k < 8; k++) begin
        n_cmp++;
        if (got_w[4*k+3][31:16] !== 16'(k)) begin
          n_bad++; $display("FAIL ovf_order rec%0d: got %0d exp %0d", k, got_w[4*k+3][31:16], k);
        end
      end
    set_rec(64'd10, $urandom, $urandom, $urandom, 5'($urandom), 1'b0);
    step();
    rvfi_valid = 0;
    repeat (6) step();
    n_cmp++;
    if (got_w.size() != 36 || got_w[35][4:3] !== 2'b01) begin
      n_bad++; $display("FAIL ovf_flag: got n=%0d gap/ovf=%b exp n=36 gap/ovf=01", got_w.size(), got_w.size() == 36 ? got_w[35][4:3] : 2'bxx);
    end
  endtask

  task automatic test_stall();
    logic [31:0] ew[4];
    do_reset();
    out_ready = 1;
    set_rec(64'd7, 32'h200, 32'hDEADBEEF, 32'h12345678, 5'd3, 1'b0);
    ew = '{32'h200, 32'hDEADBEEF, 32'h12345678, 32'h00071800};
    step(); rvfi_valid = 0;
    step(); step();
    out_ready = 0;
    repeat (5) begin
      step(); n_cmp++;
      if ({out_valid, out_last, out_data} !== {1'b1, 1'b0, 32'hDEADBEEF}) begin
        n_bad++; $display("FAIL stall_hold: got v%b l%b %h exp v1 l0 deadbeef", out_valid, out_last, out_data);
      end
    end
    out_ready = 1;
    repeat (4) begin
      step(); n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL stall_cyc: got %h exp %h", dut_vec(), exp_vec());
      end
    end
    n_cmp++;
    if (got_w.size() != 4) begin
      n_bad++; $display("FAIL stall_count: got %0d exp 4", got_w.size());
    end else
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (got_w[i] !== ew[i]) begin
          n_bad++; $display("FAIL stall_w%0d: got %h exp %h", i, got_w[i], ew[i]);
        end
      end
  endtask

  task automatic test_halt();
    do_reset();
    out_ready = 1;
    set_rec(64'd3, $urandom, $urandom, $urandom, 5'd0, 1'b1);
    step();
    set_rec(64'd4, $urandom, $urandom, $urandom, 5'd0, 1'b0);
    step();
    rvfi_valid = 0;
    repeat (3) begin
      step(); n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL halt_cyc: got %h exp %h", dut_vec(), exp_vec());
      end
    end
    n_cmp++;
    if (halted !== 1'b0) begin
      n_bad++; $display("FAIL halt_early: got %b exp 0", halted);
    end
    step();
    n_cmp++;
    if ({halted, drop_count} !== {1'b1, 16'd0}) begin
      n_bad++; $display("FAIL halt_rise: got halted %b drops %0d exp halted 1 drops 0", halted, drop_count);
    end
    repeat (6) step();
    n_cmp++;
    if (got_w.size() != 4 || halted !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL halt_ignore: got words %0d halted %b valid %b exp 4 1 0", got_w.size(), halted, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      set_rec(64'(20 + i), $urandom, $urandom, $urandom, 5'($urandom), 1'b0);
      step();
    end
    rvfi_valid = 0;
    for (int i = 0; i < 10 && !(m_busy && m_pos == 2); i++) step();
    n_cmp++;
    if (out_data !== exp_vec()[48:17] || !(m_busy && m_pos == 2)) begin
      n_bad++; $display("FAIL rstmid_pre: got %h exp %h", out_data, exp_vec()[48:17]);
    end
    rst = 1;
    step();
    rst = 0;
    n_cmp++;
    if ({out_valid, drop_count, halted} !== 18'b0) begin
      n_bad++; $display("FAIL rstmid_post: got v%b drops %0d halted %b exp 0 0 0", out_valid, drop_count, halted);
    end
    got_w.delete(); got_l.delete();
    set_rec(64'd100, $urandom, $urandom, $urandom, 5'($urandom), 1'b0);
    step();
    rvfi_valid = 0;
    repeat (6) begin
      step(); n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL rstmid_cyc: got %h exp %h", dut_vec(), exp_vec());
      end
    end
    n_cmp++;
    if (got_w.size() != 4 || got_w[3][4] !== 1'b0 || got_w[3][31:16] !== 16'd100) begin
      n_bad++; $display("FAIL rstmid_rec: got n=%0d flags %h exp n=4 order 100 gap 0", got_w.size(), got_w.size() == 4 ? got_w[3] : 32'hx);
    end
  endtask

  task automatic test_back_to_back();
    int run, maxrun;
    run = 0; maxrun = 0;
    do_reset();
    out_ready = 1;
    for (int i = 0; i < 17; i++) begin
      if (i < 3) set_rec(64'(40 + i), $urandom, $urandom, $urandom, 5'($urandom), 1'b0);
      else rvfi_valid = 0;
      step();
      run = out_valid ? run + 1 : 0;
      if (run > maxrun) maxrun = run;
    end
    n_cmp++;
    if (maxrun != 12 || got_w.size() != 12) begin
      n_bad++; $display("FAIL b2b: got run %0d words %0d exp 12 12", maxrun, got_w.size());
    end
  endtask

  task automatic test_random();
    logic [63:0] nxt;
    nxt = 64'hFFFF_FFFF_FFFF_FFFD;
    do_reset();
    for (int c = 0; c < 700; c++) begin
      if (c < 600) begin
        set_rec(nxt, $urandom, $urandom, $urandom, 5'($urandom), 1'b0);
        rvfi_valid = ($urandom % 4) < (((c / 100) % 2) ? 3 : 1);
        rvfi_trap = 1'($urandom); rvfi_mem_wmask = 4'($urandom);
        if (rvfi_valid) nxt = ($urandom % 8 == 0) ? nxt + 64'($urandom % 5) + 2 : nxt + 1;
        out_ready = ($urandom % 4) != 0;
      end else begin
        rvfi_valid = 0; out_ready = 1;
      end
      step(); n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL random c=%0d: got %h exp %h", c, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_gap();
    test_overflow();
    test_stall();
    test_halt();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
